vga_fetch: RTL and testbench
============================

VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 Parameter FRAME_WORDS, default 153600, SHALL set the 36-bit words per frame (640x480, two pixels per word).
REQ-002 Parameter READ_LAT, default 2, SHALL set the clock cycles from mem_grant to valid mem_rd_data.
REQ-003 Parameter LOG_ADDR, default 19, SHALL set the mem_addr width; bit LOG_ADDR-1 selects the bank, and the low bits are the word offset.
REQ-004 clock  in  1  system clock. One clock only; every register is clocked on posedge clock.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 frame_flag  in  1  one-cycle pulse at the end of the display frame.
REQ-007 vga_flag  in  1  one-cycle pulse from the display writer requesting the next pixel-pair word.
REQ-008 vga_pixel  out  `LOG_MEM (36)  current pixel-pair word; pixel 0 in [35:28], pixel 1 in [17:10].
REQ-009 done_vga  out  1  one-cycle pulse when the prefetch refill completes.
REQ-010 swap_req  in  1  one-cycle pulse from the capture side indicating that a new frame is complete in the other bank.
REQ-011 disp_bank  out  1  bank currently being displayed.
REQ-012 mem_req  out  1  memory read request, held high until granted.
REQ-013 mem_grant  in  1  arbiter grant; a read is accepted on any cycle where mem_req and mem_grant are both 1.
REQ-014 mem_addr  out  LOG_ADDR  read address, equal to {disp_bank, offset}; stable while mem_req is high.
REQ-015 mem_rd_data  in  36  read data, valid exactly READ_LAT cycles after acceptance.
REQ-016 underrun  out  1  sticky flag; set when a vga_flag arrives while the prefetch register is empty.

Function
REQ-017 The block SHALL hold a one-word prefetch register (pf_data, pf_valid) and a word offset counter.
REQ-018 FSM states SHALL be FETCH, WAIT and IDLE.
- FETCH: mem_req=1. Acceptance -> WAIT with the latency counter loaded to READ_LAT.
- WAIT: decrement the counter. At 0, pf_data<=mem_rd_data, pf_valid<=1, done_vga=1 for one cycle, offset increments -> IDLE.
- IDLE: wait for a request.
REQ-019 In IDLE with pf_valid=1, a vga_flag SHALL cause, on the next edge:
- vga_pixel<=pf_data
- pf_valid<=0
- state -> FETCH.
vga_pixel is therefore valid 1 cycle after vga_flag and SHALL hold until the next consumed vga_flag.
REQ-020 A vga_flag while pf_valid=0 (FETCH or WAIT) SHALL:
- set underrun;
- leave vga_pixel unchanged;
- increment offset by one extra word, so the stream stays aligned and the in-flight fetch is not disturbed.
REQ-021 The offset SHALL wrap from FRAME_WORDS-1 to 0, including on an extra underrun increment.
REQ-022 swap_req SHALL set swap_pending.
REQ-023 At frame_flag, the following SHALL happen in this order:
- if swap_pending, toggle disp_bank and clear swap_pending;
- offset<=0 and pf_valid<=0;
- re-fetch word 0 of the new disp_bank.
REQ-024 frame_flag in IDLE or FETCH SHALL go to FETCH with the new address. A mem_req already high SHALL update mem_addr only if not accepted in that same cycle; if it was accepted that cycle, follow REQ-025.
REQ-025 frame_flag in WAIT SHALL set discard. On completion, the data SHALL be dropped: no done_vga, no pf update, no offset increment. The state SHALL then go to FETCH of word 0.
REQ-026 Simultaneous swap_req and frame_flag SHALL swap at that frame_flag.
REQ-027 Simultaneous vga_flag and frame_flag: frame_flag wins; vga_flag is ignored and underrun is unchanged.
REQ-028 done_vga SHALL never be high for two consecutive cycles.
REQ-029 At most one read SHALL be outstanding at any time.

Reset
REQ-030 While reset=0, all of the following SHALL be 0:
- vga_pixel, done_vga, mem_req, mem_addr
- disp_bank, underrun, swap_pending, discard, pf_valid, offset
The state SHALL be FETCH.
REQ-031 On the first edge after reset deassertion, mem_req SHALL assert with mem_addr=0.
REQ-032 Reset asserted mid-read SHALL abandon the read; the late mem_rd_data SHALL be ignored.
REQ-033 underrun SHALL clear only on reset.

Verification
REQ-034 Reset release, grant tied high, mem_rd_data=36'hABC00DEF0 at latency -> mem_addr=0; done_vga at cycle 1+1+READ_LAT; pf_data=36'hABC00DEF0; vga_pixel=0.
REQ-035 vga_flag in IDLE -> vga_pixel=36'hABC00DEF0 next cycle; mem_req high with mem_addr=1.
REQ-036 vga_flag during WAIT -> underrun=1, vga_pixel unchanged; after completion and one more vga_flag, the next fetch address is 3, not 2.
REQ-037 Fetch through offset FRAME_WORDS-1 -> next mem_addr offset is 0, disp_bank unchanged.
REQ-038 swap_req, then frame_flag during WAIT -> no done_vga for the in-flight data; disp_bank=1; next mem_addr={1,18'd0}.
REQ-039 vga_flag and frame_flag in the same cycle, with mem_grant held low for 5 cycles -> vga_pixel unchanged; mem_req and mem_addr held stable; underrun stays 0.

Source files
------------

// File: rtl/vga_fetch.sv
// Display-side frame fetcher: prefetches one pixel-pair word ahead of the VGA writer
// and double-buffers between two memory banks, switching only at frame boundaries.
module vga_fetch #(
  parameter int FRAME_WORDS = 153600,
  parameter int READ_LAT    = 2,
  parameter int LOG_ADDR    = 19
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_flag,
  input  logic                vga_flag,
  output logic [35:0]         vga_pixel,
  output logic                done_vga,
  input  logic                swap_req,
  output logic                disp_bank,
  output logic                mem_req,
  input  logic                mem_grant,
  output logic [LOG_ADDR-1:0] mem_addr,
  input  logic [35:0]         mem_rd_data,
  output logic                underrun
);

  localparam int OFF_W = LOG_ADDR - 1;
  localparam int CNT_W = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {FETCH, WAIT, IDLE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OFF_W-1:0]   offset, offset_n;
  logic               bank_n;
  logic               swap_pending, pend_n;
  logic               discard, discard_n;
  logic               pf_valid, pf_valid_n;
  logic [35:0]        pf_data;
  logic               underrun_n;
  logic               done_n;
  logic               pf_load, pix_load, addr_load;
  logic               accept;

  function automatic logic [OFF_W-1:0] next_off(input logic [OFF_W-1:0] o);
    return (o == OFF_W'(FRAME_WORDS - 1)) ? '0 : o + OFF_W'(1);
  endfunction

  assign accept = mem_req && mem_grant;

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned (which would infer a latch); blocking '=' is correct in combinational code.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    offset_n   = offset;
    bank_n     = disp_bank;
    pend_n     = swap_pending | swap_req;
    discard_n  = discard;
    pf_valid_n = pf_valid;
    underrun_n = underrun;
    done_n     = 1'b0;
    pf_load    = 1'b0;
    pix_load   = 1'b0;
    addr_load  = 1'b0;

    case (state)
      FETCH: begin
        if (accept) begin
          state_n = WAIT;
          cnt_n   = CNT_W'(READ_LAT);
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = FETCH;
            addr_load = 1'b1;
          end else begin
            pf_load    = 1'b1;
            pf_valid_n = 1'b1;
            done_n     = 1'b1;
            offset_n   = next_off(offset);
            state_n    = IDLE;
          end
        end
      end
      IDLE: begin
        if (vga_flag && pf_valid) begin
          pix_load   = 1'b1;
          pf_valid_n = 1'b0;
          state_n    = FETCH;
          addr_load  = 1'b1;
        end
      end
      default: state_n = FETCH;
    endcase

    // A request with nothing prefetched skips a word so the stream stays aligned;
    // the address already on the bus is left alone.
    if (vga_flag && !pf_valid && !frame_flag) begin
      underrun_n = 1'b1;
      offset_n   = next_off(offset_n);
    end

    // Frame boundary overrides everything else in the cycle.
    if (frame_flag) begin
      if (pend_n) begin
        bank_n = ~disp_bank;
        pend_n = 1'b0;
      end
      offset_n   = '0;
      pf_valid_n = 1'b0;
      pf_load    = 1'b0;
      pix_load   = 1'b0;
      done_n     = 1'b0;
      addr_load  = 1'b0;
      case (state)
        FETCH: begin
          if (accept) begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end else begin
            state_n   = FETCH;
            addr_load = 1'b1;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state_n   = FETCH;
            discard_n = 1'b0;
            addr_load = 1'b1;
          end else begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end
        end
        default: begin
          state_n   = FETCH;
          addr_load = 1'b1;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      cnt          <= '0;
      offset       <= '0;
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
      discard      <= 1'b0;
      pf_valid     <= 1'b0;
      underrun     <= 1'b0;
      done_vga     <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      vga_pixel    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      offset       <= offset_n;
      disp_bank    <= bank_n;
      swap_pending <= pend_n;
      discard      <= discard_n;
      pf_valid     <= pf_valid_n;
      underrun     <= underrun_n;
      done_vga     <= done_n;
      mem_req      <= (state_n == FETCH);
      if (addr_load) mem_addr <= {bank_n, offset_n};
      if (pix_load)  vga_pixel <= pf_data;
    end
  end

  // NOTE: pf_data is a pure data register qualified by pf_valid, so it carries no reset.
  always_ff @(posedge clock) begin
    if (pf_load) pf_data <= mem_rd_data;
  end

endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch: latency-accurate memory model plus a pixel scoreboard.
module tb_vga_fetch;

  localparam int FW = 6;
  localparam int RL = 2;
  localparam int LA = 19;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_flag = 1'b0;
  logic          vga_flag = 1'b0;
  logic          swap_req = 1'b0;
  logic          mem_grant = 1'b1;
  logic [35:0]   mem_rd_data = 36'h0;
  logic [35:0]   vga_pixel;
  logic          done_vga;
  logic          disp_bank;
  logic          mem_req;
  logic [LA-1:0] mem_addr;
  logic          underrun;

  vga_fetch #(.FRAME_WORDS(FW), .READ_LAT(RL), .LOG_ADDR(LA)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_flag  (frame_flag),
    .vga_flag    (vga_flag),
    .vga_pixel   (vga_pixel),
    .done_vga    (done_vga),
    .swap_req    (swap_req),
    .disp_bank   (disp_bank),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int consec = 0;
  logic done_prev = 1'b0;
  logic [35:0] exp_q[$];

  logic          vpipe[RL];
  logic [LA-1:0] apipe[RL];

  function automatic logic [35:0] data_of(input logic [LA-1:0] a);
    return 36'hABC00DEF0 + (36'(a) << 12);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (done_vga) return;
    end
    check("done_timeout", 64'(done_vga), 64'd1);
  endtask

  task automatic consume(input logic [LA-1:0] a, input logic [LA-1:0] next_a);
    logic [35:0] e;
    exp_q.push_back(data_of(a));
    vga_flag = 1'b1;
    step();
    vga_flag = 1'b0;
    e = exp_q.pop_front();
    check("pixel", 64'(vga_pixel), 64'(e));
    check("next_req", 64'(mem_req), 64'd1);
    check("next_addr", 64'(mem_addr), 64'(next_a));
  endtask

  // Memory: a read accepted in cycle c returns its data during cycle c+RL.
  always @(posedge clock) begin
    logic          acc;
    logic [LA-1:0] a;
    acc = mem_req && mem_grant && reset;
    a   = mem_addr;
    #1;
    for (int k = RL - 1; k > 0; k--) begin
      vpipe[k] = vpipe[k-1];
      apipe[k] = apipe[k-1];
    end
    vpipe[0] = acc;
    apipe[0] = a;
    mem_rd_data = vpipe[RL-1] ? data_of(apipe[RL-1]) : 36'hDEADBEEF5;
  end

  always @(negedge clock) begin
    if (done_vga) begin
      done_cnt++;
      if (done_prev) consec++;
    end
    done_prev = done_vga;
  end

  initial begin
    int n;
    int d0;
    for (int k = 0; k < RL; k++) begin
      vpipe[k] = 1'b0;
      apipe[k] = '0;
    end

    repeat (2) @(posedge clock);
    #1;
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_pixel", 64'(vga_pixel), 64'd0);
    check("rst_done", 64'(done_vga), 64'd0);
    check("rst_bank", 64'(disp_bank), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);

    // First fetch after reset release
    reset = 1'b1;
    step();
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", 64'(mem_addr), 64'd0);
    wait_done(n);
    check("done_lat", 64'(n + 1), 64'(1 + 1 + RL));
    check("pixel_before_flag", 64'(vga_pixel), 64'd0);
    step();
    check("done_one_cycle", 64'(done_vga), 64'd0);

    consume(LA'(0), LA'(1));

    // Underrun while the word-1 read is in flight
    step();
    vga_flag = 1'b1;
    step();
    vga_flag = 1'b0;
    check("underrun_set", 64'(underrun), 64'd1);
    check("underrun_pixel", 64'(vga_pixel), 64'(data_of(LA'(0))));
    wait_done(n);
    consume(LA'(1), LA'(3));

    // Run to the end of the frame and wrap the offset
    for (int w = 3; w < FW; w++) begin
      wait_done(n);
      consume(LA'(w), LA'((w + 1) % FW));
    end
    check("wrap_bank", 64'(disp_bank), 64'd0);

    // Swap request, then frame boundary while the read is in flight
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    d0 = done_cnt;
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    check("swap_bank", 64'(disp_bank), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (mem_req) break;
      step();
    end
    check("swap_req_up", 64'(mem_req), 64'd1);
    check("swap_addr", 64'(mem_addr), 64'h40000);
    check("discard_no_done", 64'(done_cnt), 64'(d0));
    wait_done(n);
    consume(LA'(19'h40000), LA'(19'h40001));

    // Reset in the middle of a read
    step();
    reset = 1'b0;
    #1;
    check("midrst_req", 64'(mem_req), 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    check("midrst_bank", 64'(disp_bank), 64'd0);
    check("midrst_pixel", 64'(vga_pixel), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    step();
    reset = 1'b1;
    step();
    check("rerun_req", 64'(mem_req), 64'd1);
    check("rerun_addr", 64'(mem_addr), 64'd0);
    wait_done(n);
    check("rerun_lat", 64'(n + 1), 64'(1 + 1 + RL));

    // vga_flag coincident with frame_flag, grant withheld
    mem_grant = 1'b0;
    vga_flag = 1'b1;
    frame_flag = 1'b1;
    step();
    vga_flag = 1'b0;
    frame_flag = 1'b0;
    check("coinc_pixel", 64'(vga_pixel), 64'd0);
    check("coinc_underrun", 64'(underrun), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("hold_req", 64'(mem_req), 64'd1);
      check("hold_addr", 64'(mem_addr), 64'd0);
      step();
    end
    mem_grant = 1'b1;
    wait_done(n);
    consume(LA'(0), LA'(1));
    check("final_underrun", 64'(underrun), 64'd0);
    check("done_consecutive", 64'(consec), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
